// File: rtl/serial_frame_capture_pkg.sv
// serial_pkg: shared FSM state type and default frame width for serial_frame_capture.
// Contents: state_t {HUNT, SHIFT}, FRAME_WIDTH_DEF.
package serial_pkg;
    localparam int FRAME_WIDTH_DEF = 8;
    typedef enum logic {HUNT, SHIFT} state_t;
endpackage

// File: rtl/serial_frame_capture_if.sv
// serial_frame_capture_if: serial input, frame alignment and valid/ready output bus.
// Ports (slave = capture block): in en, serial_in, frame_start, out_ready;
// out out_valid, out_data, overrun, frame_err (+ out_level, out_thermo_ok under THERMO_DECODE_EN).
interface serial_frame_capture_if
    import serial_pkg::*;
#(
    parameter int WIDTH = FRAME_WIDTH_DEF
);
    localparam int CNT_W = $clog2(WIDTH);
    logic             en;
    logic             serial_in;
    logic             frame_start;
    logic             out_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             overrun;
    logic             frame_err;
`ifdef THERMO_DECODE_EN
    logic [CNT_W-1:0] out_level;
    logic             out_thermo_ok;
`endif
    modport slave (
        input  en, serial_in, frame_start, out_ready,
`ifdef THERMO_DECODE_EN
        output out_level, out_thermo_ok,
`endif
        output out_valid, out_data, overrun, frame_err
    );
    modport master (
        output en, serial_in, frame_start, out_ready,
`ifdef THERMO_DECODE_EN
        input  out_level, out_thermo_ok,
`endif
        input  out_valid, out_data, overrun, frame_err
    );
endinterface

// File: rtl/serial_frame_capture_thermo_decoder.sv
// thermo_decoder: combinational check that a word is 2^(k+1)-1; reports k.
// Ports: word_i [WIDTH] in; level_o [CNT_W] out (k, else 0); ok_o out (word is a thermometer code).
module thermo_decoder
    import serial_pkg::*;
#(
    parameter int WIDTH = FRAME_WIDTH_DEF
) (
    input  logic [WIDTH-1:0]         word_i,
    output logic [$clog2(WIDTH)-1:0] level_o,
    output logic                     ok_o
);
    localparam int CNT_W = $clog2(WIDTH);
    always_comb begin
        level_o = '0;
        ok_o    = 1'b0;
        for (int k = 0; k < WIDTH; k++) begin
            if (word_i == WIDTH'((64'd1 << (k + 1)) - 64'd1)) begin
                level_o = CNT_W'(k);
                ok_o    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/serial_frame_capture.sv
// serial_frame_capture: deserialises LSB-first frames into WIDTH-bit words on a valid/ready bus.
// Ports: clock, clear (sync active-high reset); bus (serial_frame_capture_if.slave).
// Macro THERMO_DECODE_EN adds registered out_level/out_thermo_ok via thermo_decoder.
module serial_frame_capture
    import serial_pkg::*;
#(
    parameter int WIDTH = FRAME_WIDTH_DEF
) (
    input logic                   clock,
    input logic                   clear,
    serial_frame_capture_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);
    state_t           state_q, state_d;
    logic [CNT_W-1:0] bitcnt_q, bitcnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d, data_q, data_d, word;
    logic             valid_q, valid_d, overrun_q, overrun_d, ferr_q, ferr_d;
    logic             done, load;
    assign word = {bus.serial_in, shreg_q[WIDTH-2:0]};
    assign done = bus.en && state_q == SHIFT && !bus.frame_start && bitcnt_q == CNT_W'(WIDTH - 1);
    // A completed word is taken when the holding register is empty or being drained this cycle.
    assign load      = done && (!valid_q || bus.out_ready);
    assign overrun_d = done && !load;
    assign valid_d   = load ? 1'b1 : (valid_q && bus.out_ready) ? 1'b0 : valid_q;
    assign data_d    = load ? word : data_q;
    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        ferr_d   = bus.en && bus.frame_start && state_q == SHIFT;
        if (bus.en && bus.frame_start) begin
            // frame_start always (re)starts a frame with the current bit as bit 0
            state_d  = SHIFT;
            bitcnt_d = CNT_W'(1);
            shreg_d  = {{(WIDTH - 1){1'b0}}, bus.serial_in};
        end else if (bus.en && state_q == SHIFT) begin
            if (done) begin
                state_d  = HUNT;
                bitcnt_d = '0;
            end else begin
                shreg_d[bitcnt_q] = bus.serial_in;
                bitcnt_d          = bitcnt_q + CNT_W'(1);
            end
        end
    end
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q   <= HUNT;
            bitcnt_q  <= '0;
            shreg_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bitcnt_q  <= bitcnt_d;
            shreg_q   <= shreg_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            ferr_q    <= ferr_d;
        end
    end
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.overrun   = overrun_q;
    assign bus.frame_err = ferr_q;
`ifdef THERMO_DECODE_EN
    logic [CNT_W-1:0] level_w, level_q;
    logic             ok_w, ok_q;
    thermo_decoder #(.WIDTH(WIDTH)) u_thermo (
        .word_i  (word),
        .level_o (level_w),
        .ok_o    (ok_w)
    );
    always_ff @(posedge clock) begin
        if (clear) begin
            level_q <= '0;
            ok_q    <= 1'b0;
        end else if (load) begin
            level_q <= level_w;
            ok_q    <= ok_w;
        end
    end
    assign bus.out_level     = level_q;
    assign bus.out_thermo_ok = ok_q;
`endif
endmodule

// File: tb/tb_serial_frame_capture.sv
// tb_serial_frame_capture: directed frames with a scoreboard monitor on the output bus.
module tb_serial_frame_capture;
    import serial_pkg::*;
    localparam int W = 8;
    typedef struct packed {
        logic [W-1:0] d;
        logic [2:0]   lvl;
        logic         ok;
    } exp_t;
    logic clock = 1'b0;
    logic clear = 1'b1;
    exp_t q[$];
    int   total = 0, bad = 0, ovr_n = 0, ferr_n = 0, vcyc = 0;
    logic pv = 1'b0, px = 1'b0;
    always #5 clock = ~clock;
    serial_frame_capture_if #(.WIDTH(W)) bus ();
    serial_frame_capture #(.WIDTH(W)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );
    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", n, a, e);
        end
    endtask
    function automatic exp_t mk(input logic [7:0] d, input logic [2:0] l, input logic ok);
        exp_t e;
        e.d = d;
        e.lvl = l;
        e.ok = ok;
        return e;
    endfunction
    task automatic drive(input logic e, input logic fs, input logic b);
        bus.en = e;
        bus.frame_start = fs;
        bus.serial_in = b;
        @(posedge clock);
        #1;
    endtask
    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0);
    endtask
    task automatic send_frame(input logic [7:0] w, input bit tog, input bit rl);
        for (int i = 0; i < 8; i++) begin
            if (rl && i == 7) bus.out_ready = 1'b1;
            drive(1'b1, i == 0, w[i]);
            if (tog && i < 7) drive(1'b0, 1'b1, ~w[i]);
        end
    endtask
    task automatic clr_counts();
        ovr_n = 0;
        ferr_n = 0;
        vcyc = 0;
    endtask
    // Monitor: a word is presented when out_valid rises or stays high right after a transfer.
    initial forever begin
        exp_t e;
        @(negedge clock);
        if (clear) begin
            pv = 1'b0;
            px = 1'b0;
        end else begin
            if (bus.overrun) ovr_n++;
            if (bus.frame_err) ferr_n++;
            if (bus.out_valid) vcyc++;
            if (bus.out_valid && (!pv || px)) begin
                if (q.size() == 0) chk("sb_unexpected_word", bus.out_data, 32'hxxxx_xxxx);
                else begin
                    e = q.pop_front();
                    chk("sb_data", bus.out_data, e.d);
`ifdef THERMO_DECODE_EN
                    chk("sb_level", bus.out_level, e.lvl);
                    chk("sb_thermo_ok", bus.out_thermo_ok, e.ok);
`endif
                end
            end
            pv = bus.out_valid;
            px = bus.out_valid && bus.out_ready;
        end
    end
    initial begin
        bus.en = 0;
        bus.serial_in = 0;
        bus.frame_start = 0;
        bus.out_ready = 0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_data", bus.out_data, 0);
        chk("rst_overrun", bus.overrun, 0);
        chk("rst_frame_err", bus.frame_err, 0);
`ifdef THERMO_DECODE_EN
        chk("rst_level", bus.out_level, 0);
        chk("rst_thermo_ok", bus.out_thermo_ok, 0);
`endif
        clear = 0;
        // 1: single frame, consumer always ready
        clr_counts();
        bus.out_ready = 1;
        q.push_back(mk(8'h07, 3'd2, 1'b1));
        send_frame(8'h07, 0, 0);
        chk("t1_latency_valid", bus.out_valid, 1);
        idle(3);
        chk("t1_valid_cycles", vcyc, 1);
        chk("t1_pending", q.size(), 0);
        chk("t1_overruns", ovr_n, 0);
        // 2: back-to-back frames while stalled
        clr_counts();
        bus.out_ready = 0;
        q.push_back(mk(8'h0F, 3'd3, 1'b1));
        send_frame(8'h0F, 0, 0);
        send_frame(8'hFF, 0, 0);
        chk("t2_overrun_at_completion", bus.overrun, 1);
        idle(2);
        chk("t2_data_held", bus.out_data, 8'h0F);
        chk("t2_valid_held", bus.out_valid, 1);
        chk("t2_overruns", ovr_n, 1);
        chk("t2_pending", q.size(), 0);
        bus.out_ready = 1;
        idle(1);
        bus.out_ready = 0;
        chk("t2_drained", bus.out_valid, 0);
        // 3: transfer coincides with completion
        clr_counts();
        q.push_back(mk(8'h3F, 3'd5, 1'b1));
        q.push_back(mk(8'h01, 3'd0, 1'b1));
        send_frame(8'h3F, 0, 0);
        idle(1);
        send_frame(8'h01, 0, 1);
        bus.out_ready = 0;
        chk("t3_valid_kept", bus.out_valid, 1);
        chk("t3_data_new", bus.out_data, 8'h01);
        idle(2);
        chk("t3_overruns", ovr_n, 0);
        chk("t3_pending", q.size(), 0);
        bus.out_ready = 1;
        idle(1);
        // 4: early frame_start breaks a partial frame
        clr_counts();
        q.push_back(mk(8'h1F, 3'd4, 1'b1));
        for (int i = 0; i < 4; i++) drive(1'b1, i == 0, i[0]);
        send_frame(8'h1F, 0, 0);
        idle(2);
        chk("t4_frame_errs", ferr_n, 1);
        chk("t4_overruns", ovr_n, 0);
        chk("t4_pending", q.size(), 0);
        // 5: en toggling, garbage on disabled cycles
        clr_counts();
        bus.out_ready = 0;
        q.push_back(mk(8'hA5, 3'd0, 1'b0));
        send_frame(8'hA5, 1, 0);
        idle(2);
        chk("t5_data", bus.out_data, 8'hA5);
        chk("t5_valid", bus.out_valid, 1);
        chk("t5_frame_errs", ferr_n, 0);
        chk("t5_pending", q.size(), 0);
        // 6: clear mid-frame, then a fresh frame
        clr_counts();
        for (int i = 0; i < 5; i++) drive(1'b1, i == 0, 1'b1);
        clear = 1;
        drive(1'b1, 1'b0, 1'b1);
        chk("t6_clr_valid", bus.out_valid, 0);
        chk("t6_clr_data", bus.out_data, 0);
        chk("t6_clr_overrun", bus.overrun, 0);
        chk("t6_clr_frame_err", bus.frame_err, 0);
`ifdef THERMO_DECODE_EN
        chk("t6_clr_level", bus.out_level, 0);
        chk("t6_clr_thermo_ok", bus.out_thermo_ok, 0);
`endif
        clear = 0;
        q.push_back(mk(8'h03, 3'd1, 1'b1));
        send_frame(8'h03, 0, 0);
        idle(1);
        chk("t6_data", bus.out_data, 8'h03);
        chk("t6_valid", bus.out_valid, 1);
        chk("t6_pulses", ovr_n + ferr_n, 0);
        chk("t6_pending", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
